// File: rtl/gat_feat_readback.sv
// Host-side reader for the GAT new-feature BRAM port B.
// Walks a word range after gat_ready and streams it out over valid/ready with tlast.
module gat_feat_readback #(
  parameter int unsigned NEW_FEATURE_WIDTH  = 32,
  parameter int unsigned NUM_SUBGRAPHS      = 2708,
  parameter int unsigned NUM_FEATURE_OUT    = 16,
  parameter int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int unsigned BRAM_RD_LAT        = 2,
  parameter int unsigned FIFO_DEPTH         = BRAM_RD_LAT + 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            gat_ready,
  input  logic                            start,
  input  logic [NEW_FEATURE_ADDR_W-1:0]   rd_base,
  input  logic [NEW_FEATURE_ADDR_W:0]     rd_len,
  output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int unsigned AW    = NEW_FEATURE_ADDR_W;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned SW    = AW + 2;
  localparam int unsigned DW    = NEW_FEATURE_WIDTH;
  localparam int unsigned LAT   = BRAM_RD_LAT;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = FC_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_RDY, S_STREAM, S_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       base_q, base_d;
  logic [CW-1:0]       len_q, len_d;
  logic [CW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic [SW-1:0]       addr_q, addr_d;
  logic [LAT-1:0]      pipe_q, pipe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FC_W-1:0]     fcnt_q, fcnt_d;
  logic [DW-1:0]       mem_q [FIFO_DEPTH];

  logic                pop_c;
  logic                wr_c;
  logic                last_c;
  logic                room_c;
  logic                issue_c;
  logic                req_bad_c;
  logic [FC_W-1:0]     inflight_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Stream side is decoded straight from the FIFO registers.
  assign m_tvalid        = (fcnt_q != '0);
  assign m_tdata         = mem_q[rd_ptr_q];
  assign last_c          = (out_cnt_q == len_q - CW'(1));
  assign m_tlast         = m_tvalid & last_c;
  assign pop_c           = m_tvalid & m_tready;
  assign wr_c            = pipe_q[LAT-1];
  assign feat_bram_addrb = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

  assign req_bad_c = (rd_len == '0) ||
                     (({2'b00, rd_base} + {1'b0, rd_len}) > SW'(NEW_FEATURE_DEPTH));

  always_comb begin
    inflight_c = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      inflight_c = inflight_c + FC_W'(pipe_q[i]);
    end
  end

  // Credit: a word popping this cycle frees its slot for a new read.
  assign room_c  = ((SUM_W'(inflight_c) + SUM_W'(fcnt_q) - SUM_W'(pop_c)) < SUM_W'(FIFO_DEPTH));
  assign issue_c = (state_q == S_STREAM) && (issue_cnt_q < len_q) && room_c;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    pipe_d      = LAT'({pipe_q, issue_c});
    wr_ptr_d    = wr_c  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fcnt_d      = fcnt_q + FC_W'(wr_c) - FC_W'(pop_c);

    if (pop_c) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end
    if (issue_c) begin
      addr_d      = {AW'(base_q + AW'(issue_cnt_q)), 2'b00};
      issue_cnt_d = issue_cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_bad_c) begin
            err_d = 1'b1;
          end else begin
            base_d      = rd_base;
            len_d       = rd_len;
            issue_cnt_d = '0;
            out_cnt_d   = '0;
            busy_d      = 1'b1;
            state_d     = gat_ready ? S_STREAM : S_WAIT_RDY;
          end
        end
      end
      S_WAIT_RDY: begin
        if (gat_ready) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (issue_cnt_d == len_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (pop_c && last_c) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      addr_q      <= '0;
      pipe_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      addr_q      <= addr_d;
      pipe_q      <= pipe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fcnt_q      <= fcnt_d;
    end
  end

  // Cleared on reset so no stale word can surface at the FIFO head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_c) begin
      mem_q[wr_ptr_q] <= feat_bram_dout;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_c && !pop_c && (fcnt_q == FC_W'(FIFO_DEPTH))));

endmodule

// File: doc/gat_feat_readback.md
Name: gat_feat_readback

Overview:
- Host-side reader for the final new-feature BRAM port B of the GAT accelerator top.
- After the accelerator raises gat_ready, it walks a requested range of the feature BRAM using byte addresses.
- It absorbs the fixed BRAM read latency and emits the words on a valid/ready stream with backpressure, ending with tlast.
- It sits between the accelerator's feat_bram_addrb/feat_bram_dout port and the host DMA.

Parameters:
- NEW_FEATURE_WIDTH, 32, width of one feature word.
- NUM_SUBGRAPHS, 2708, number of subgraphs.
- NUM_FEATURE_OUT, 16, features per subgraph.
- NEW_FEATURE_DEPTH, NUM_SUBGRAPHS*NUM_FEATURE_OUT, number of words in the feature BRAM.
- NEW_FEATURE_ADDR_W, $clog2(NEW_FEATURE_DEPTH), word-index width.
- BRAM_RD_LAT, 2, cycles from an addrb update to the edge at which dout is sampled valid (range 1..4).
- FIFO_DEPTH, BRAM_RD_LAT+2, output buffer entries.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- gat_ready  in  1  level; the accelerator's results are valid.
- start  in  1  single-cycle request pulse.
- rd_base  in  NEW_FEATURE_ADDR_W  first word index to read.
- rd_len  in  NEW_FEATURE_ADDR_W+1  number of words to read.
- feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  byte address {word_idx,2'b00}.
- feat_bram_dout  in  NEW_FEATURE_WIDTH  BRAM read data.
- m_tdata  out  NEW_FEATURE_WIDTH  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  marks the final word.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last handshake.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: all outputs are 0; the FIFO, the in-flight pipeline and all counters are cleared; state = IDLE. Asserting rst mid-transfer aborts immediately with no done pulse; data in flight is discarded.
- States: IDLE, WAIT_RDY, STREAM, FLUSH.
- IDLE:
  - start with rd_len==0 or rd_base+rd_len > NEW_FEATURE_DEPTH: err pulses the next cycle; stay in IDLE.
  - Otherwise latch base and len, set busy, issue_cnt=0, out_cnt=0. Go to STREAM if gat_ready=1, else to WAIT_RDY.
- While busy, start is ignored (no err).
- WAIT_RDY: go to STREAM on the first cycle gat_ready=1.
- STREAM, issue rule:
  - A read issues on a cycle when issue_cnt<len and (inflight + fifo_count) < FIFO_DEPTH. Count any word leaving the FIFO in the same cycle as freeing a slot.
  - Issue registers feat_bram_addrb = (base+issue_cnt)<<2 and increments issue_cnt.
  - feat_bram_addrb holds its last value when no read issues.
- Read data capture:
  - A BRAM_RD_LAT-deep valid shift register tracks issued reads.
  - feat_bram_dout is written into the FIFO on the edge BRAM_RD_LAT cycles after the issuing edge.
  - The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
- Output:
  - m_tvalid = FIFO non-empty; m_tdata = FIFO head. Outputs are registered or FIFO-head; there is no combinational path from m_tready to m_tvalid.
  - Handshake = m_tvalid & m_tready; it pops the FIFO and increments out_cnt.
  - m_tlast = m_tvalid & (out_cnt==len-1).
  - m_tdata/m_tlast stay stable while m_tvalid=1 and m_tready=0.
- Throughput and latency:
  - With m_tready held high: start sampled at edge 0 (gat_ready=1); first addrb update at edge 1; m_tvalid first high after edge 1+BRAM_RD_LAT.
  - One word per cycle thereafter.
- FLUSH: entered when issue_cnt==len. On the handshake of the last word, go to IDLE, busy=0, and pulse done for one cycle in the following cycle.
- gat_ready falling during STREAM/FLUSH does not stall the transfer; it is sampled only at the start of a transfer.
- Arithmetic:
  - Counters are NEW_FEATURE_ADDR_W+1 bits.
  - Address arithmetic does not wrap, because requests are bound-checked at start.
  - rd_len == NEW_FEATURE_DEPTH with rd_base=0 is legal.

Test Plan:
- gat_ready=1, start base=0 len=16, m_tready=1 -> addrb steps 0x0,0x4..0x3C; m_tvalid is first high 3 cycles after start (LAT=2); 16 consecutive beats equal to BRAM contents; tlast on beat 16; done pulses once; busy drops.
- Same request with m_tready toggled 1,0,0,1 pseudo-randomly -> no loss or duplication; data stable while stalled; FIFO count ≤ 4; inflight+fifo ≤ FIFO_DEPTH at every cycle.
- start with gat_ready=0, then gat_ready rises 20 cycles later -> addrb does not change and m_tvalid stays 0 until gat_ready is high; then a normal stream of len words.
- start len=0, and separately base=43320 len=10 (exceeds 43328) -> err pulses for one cycle; busy, m_tvalid and done stay 0.
- Full range base=0 len=43328 -> last addrb = 0x2A4FC; tlast on word 43328; done once.
- rst asserted mid-stream at beat 5 of 16, then a new start base=32 len=4 -> outputs 0 immediately; only the 4 new words appear, with no stale data from the aborted transfer.
